// File: rtl/tri_feeder.sv
// Triangle issuer feeding rast: drops off-screen triangles, queues the rest, honours rast stalls.
// Optional TRI_FEEDER_STATS_EN adds saturating drop/issue counters.
module tri_feeder #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int DEPTH  = 4,
  parameter int CNTW   = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]      in_tri_S,
  input  logic [COLORS-1:0][SIGFIG-1:0]               in_color_U,
  input  logic                                        in_valid_H,
  output logic                                        in_ready_H,
  input  logic [1:0][SIGFIG-1:0]                      screen_RnnnnS,
  input  logic                                        halt_RnnnnL,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]      tri_R10S,
  output logic [COLORS-1:0][SIGFIG-1:0]               color_R10U,
  output logic                                        validTri_R10H,
  output logic                                        idle_H
`ifdef TRI_FEEDER_STATS_EN
  ,
  output logic [CNTW-1:0]                             stat_drop_U,
  output logic [CNTW-1:0]                             stat_issue_U
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]          col_t;

  tri_t          mem_tri [DEPTH];
  col_t          mem_col [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          on_screen;
  logic          accept;
  logic          push;
  logic          xfer;
  logic          load;

  assign full       = (count == (PW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign in_ready_H = !rst && !full;
  assign accept     = in_valid_H && in_ready_H;
  assign push       = accept && on_screen;
  assign xfer       = validTri_R10H && halt_RnnnnL;
  assign load       = (!validTri_R10H || xfer) && !empty;
  assign idle_H     = empty && !validTri_R10H;

  // Signed bounds: a set sign bit means the coordinate is below zero.
  always_comb begin
    on_screen = 1'b1;
    for (int unsigned v = 0; v < VERTS; v++) begin
      if (in_tri_S[v][0][SIGFIG-1] ||
          ($signed(in_tri_S[v][0]) > $signed(screen_RnnnnS[0])))
        on_screen = 1'b0;
      if (in_tri_S[v][1][SIGFIG-1] ||
          ($signed(in_tri_S[v][1]) > $signed(screen_RnnnnS[1])))
        on_screen = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_tri[wr_ptr] <= in_tri_S;
      mem_col[wr_ptr] <= in_color_U;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      validTri_R10H <= 1'b0;
      tri_R10S      <= '0;
      color_R10U    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (load) begin
        tri_R10S      <= mem_tri[rd_ptr];
        color_R10U    <= mem_col[rd_ptr];
        rd_ptr        <= rd_ptr + PW'(1);
        validTri_R10H <= 1'b1;
      end else if (xfer) begin
        validTri_R10H <= 1'b0;
      end
      if (push && !load)
        count <= count + (PW+1)'(1);
      else if (!push && load)
        count <= count - (PW+1)'(1);
    end
  end

`ifdef TRI_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_drop_U  <= '0;
      stat_issue_U <= '0;
    end else begin
      if (accept && !on_screen && (stat_drop_U != '1))
        stat_drop_U <= stat_drop_U + CNTW'(1);
      if (xfer && (stat_issue_U != '1))
        stat_issue_U <= stat_issue_U + CNTW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tri_feeder.sv
// Scoreboard bench for tri_feeder: driver queues expected issues, monitor checks rast-side transfers.
module tb_tri_feeder;
  localparam int SIGFIG = 24;
  localparam int CNTW   = 4;
  localparam int SCRI   = 1 << 19;

  typedef logic [2:0][2:0][SIGFIG-1:0] tri_t;
  typedef logic [2:0][SIGFIG-1:0]      col_t;
  typedef struct packed { tri_t t; col_t c; } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid_H = 1'b0;
  logic in_ready_H;
  logic halt_RnnnnL = 1'b1;
  logic validTri_R10H;
  logic idle_H;
  tri_t in_tri_S = '0;
  tri_t tri_R10S;
  col_t in_color_U = '0;
  col_t color_R10U;
  logic [1:0][SIGFIG-1:0] screen_RnnnnS;
`ifdef TRI_FEEDER_STATS_EN
  logic [CNTW-1:0] stat_drop_U;
  logic [CNTW-1:0] stat_issue_U;
`endif

  item_t exp_q[$];
  int compared   = 0;
  int mismatched = 0;
  bit t3_done    = 1'b0;
  bit rnd_done   = 1'b0;

  always #5 clk = ~clk;

  tri_feeder #(.SIGFIG(SIGFIG), .VERTS(3), .AXIS(3), .COLORS(3), .DEPTH(4), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_tri_S(in_tri_S), .in_color_U(in_color_U),
    .in_valid_H(in_valid_H), .in_ready_H(in_ready_H),
    .screen_RnnnnS(screen_RnnnnS), .halt_RnnnnL(halt_RnnnnL),
    .tri_R10S(tri_R10S), .color_R10U(color_R10U),
    .validTri_R10H(validTri_R10H), .idle_H(idle_H)
`ifdef TRI_FEEDER_STATS_EN
    , .stat_drop_U(stat_drop_U), .stat_issue_U(stat_issue_U)
`endif
  );

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tri_t mk_tri(input int x0, input int y0, input int x1, input int y1,
                                  input int x2, input int y2, input int z);
    tri_t t;
    t[0][0] = SIGFIG'(x0); t[0][1] = SIGFIG'(y0); t[0][2] = SIGFIG'(z);
    t[1][0] = SIGFIG'(x1); t[1][1] = SIGFIG'(y1); t[1][2] = SIGFIG'(z);
    t[2][0] = SIGFIG'(x2); t[2][1] = SIGFIG'(y2); t[2][2] = SIGFIG'(z);
    return t;
  endfunction

  function automatic col_t mk_col(input int r, input int g, input int b);
    col_t c;
    c[0] = SIGFIG'(r); c[1] = SIGFIG'(g); c[2] = SIGFIG'(b);
    return c;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input tri_t t, input col_t c, input bit on);
    int n = 0;
    in_tri_S   = t;
    in_color_U = c;
    in_valid_H = 1'b1;
    @(negedge clk);
    while (!in_ready_H) begin
      n++;
      if (n > 200) begin
        compared++;
        mismatched++;
        $display("FAIL send_timeout: got in_ready_H=0 for %0d cycles expected 1", n);
        in_valid_H = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (on) exp_q.push_back({t, c});
    @(posedge clk);
    #1;
    in_valid_H = 1'b0;
  endtask

  // Monitor: checks stall stability and every rast transfer against the queue.
  initial begin
    logic p_v, p_h, p_r;
    tri_t p_t;
    col_t p_c;
    item_t e;
    p_v = 1'b0; p_h = 1'b1; p_r = 1'b1; p_t = '0; p_c = '0;
    forever begin
      @(negedge clk);
      if (p_v && !p_h && !p_r) begin
        chk("hold_valid", validTri_R10H, 1'b1);
        chk("hold_data", {tri_R10S, color_R10U}, {p_t, p_c});
      end
      if (validTri_R10H && halt_RnnnnL && !rst) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_issue: got %0h expected none", {tri_R10S, color_R10U});
        end else begin
          e = exp_q.pop_front();
          chk("issue_data", {tri_R10S, color_R10U}, e);
        end
      end
      p_v = validTri_R10H; p_h = halt_RnnnnL; p_r = rst;
      p_t = tri_R10S; p_c = color_R10U;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tri_t t;
    int k, kind, n;
    screen_RnnnnS[0] = SIGFIG'(SCRI);
    screen_RnnnnS[1] = SIGFIG'(SCRI);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", validTri_R10H, 1'b0);
    chk("rst_ready", in_ready_H, 1'b0);
    chk("rst_idle", idle_H, 1'b1);
    chk("rst_tri", tri_R10S, '0);
    chk("rst_color", color_R10U, '0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: single triangle latency
    send(mk_tri(0, 0, 100, 0, 0, 100, 5), mk_col(1, 2, 3), 1'b1);
    @(negedge clk); chk("t1_after_accept", validTri_R10H, 1'b0);
    @(negedge clk); chk("t1_valid_next", validTri_R10H, 1'b1);
    @(negedge clk); chk("t1_low_after_xfer", validTri_R10H, 1'b0);

    // 2: stall hold
    @(posedge clk); #1; halt_RnnnnL = 1'b0;
    send(mk_tri(7, 8, 9, 10, 11, 12, 13), mk_col(40, 50, 60), 1'b1);
    repeat (12) @(negedge clk);
    chk("t2_still_valid", validTri_R10H, 1'b1);
    @(posedge clk); #1; halt_RnnnnL = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("t2_low_after_xfer", validTri_R10H, 1'b0);

    // 3: fill while stalled, then back-to-back drain
    @(posedge clk); #1; halt_RnnnnL = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(mk_tri(10*i+1, 10*i+2, 10*i+3, 10*i+4, 10*i+5, 10*i+6, i),
               mk_col(i, 2*i, 3*i), 1'b1);
        t3_done = 1'b1;
      end
    join_none
    repeat (20) @(negedge clk);
    chk("t3_ready_low", in_ready_H, 1'b0);
    chk("t3_accepted", exp_q.size(), 5);
    chk("t3_valid", validTri_R10H, 1'b1);
    @(posedge clk); #1; halt_RnnnnL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_back_to_back", validTri_R10H, 1'b1);
    end
    n = 0;
    while (!t3_done && n < 100) begin @(posedge clk); n++; end
    chk("t3_sender_done", t3_done, 1'b1);
    @(posedge clk); #1;
    repeat (6) @(negedge clk);
    chk("t3_drained", exp_q.size(), 0);

    // 4: off-screen drops and inclusive boundaries
    @(posedge clk); #1;
    send(mk_tri(-1, 0, 10, 10, 20, 20, 0), mk_col(9, 9, 9), 1'b0);
    send(mk_tri(0, 0, 10, SCRI + 1, 20, 20, 0), mk_col(8, 8, 8), 1'b0);
    send(mk_tri(SCRI, SCRI, 0, 0, SCRI, 0, -7), mk_col(7, 7, 7), 1'b1);
    repeat (5) @(negedge clk);
    chk("t4_drained", exp_q.size(), 0);
`ifdef TRI_FEEDER_STATS_EN
    chk("t4_stat_drop", stat_drop_U, 2);
`endif

    // 5: reset mid-operation
    @(posedge clk); #1; halt_RnnnnL = 1'b0;
    for (int i = 0; i < 4; i++)
      send(mk_tri(i, i, i, i, i, i, i), mk_col(100 + i, 0, 0), 1'b1);
    @(negedge clk); chk("t5_busy", idle_H, 1'b0);
    @(posedge clk); #1; rst = 1'b1; exp_q.delete();
    @(negedge clk); chk("t5_ready_in_rst", in_ready_H, 1'b0);
    @(negedge clk);
    chk("t5_valid_cleared", validTri_R10H, 1'b0);
    chk("t5_idle", idle_H, 1'b1);
    @(posedge clk); #1; rst = 1'b0; halt_RnnnnL = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_no_stale", validTri_R10H, 1'b0);
`ifdef TRI_FEEDER_STATS_EN
    chk("t5_stat_issue_clr", stat_issue_U, 0);
`endif

    // 6: issue counter saturation
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++)
      send(mk_tri(i, 2*i, 3*i, 4*i, 5*i, 6*i, 0), mk_col(i, i, i), 1'b1);
    repeat (8) @(negedge clk);
    chk("t6_drained", exp_q.size(), 0);
`ifdef TRI_FEEDER_STATS_EN
    chk("t6_stat_issue_sat", stat_issue_U, 15);
`endif

    // 7: random valid/halt against the queue model
    @(posedge clk); #1;
    fork
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          halt_RnnnnL = ($urandom_range(0, 3) != 0);
        end
        halt_RnnnnL = 1'b1;
      end
    join_none
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      for (int v = 0; v < 3; v++) begin
        t[v][0] = SIGFIG'($urandom_range(0, SCRI));
        t[v][1] = SIGFIG'($urandom_range(0, SCRI));
        t[v][2] = SIGFIG'($urandom);
      end
      k = $urandom_range(0, 2);
      kind = $urandom_range(0, 4);
      if (kind == 0) t[k][0] = SIGFIG'(-$urandom_range(1, 100));
      if (kind == 1) t[k][1] = SIGFIG'(SCRI + $urandom_range(1, 100));
      send(t, mk_col($urandom_range(0, 255), $urandom_range(0, 255), i), kind > 1);
    end
    rnd_done = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || !idle_H) && n < 300) begin @(negedge clk); n++; end
    chk("final_drain", exp_q.size(), 0);
    chk("final_idle", idle_H, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
